// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - registered N-requester arbiter, fixed-priority or round-robin, grant held until ack
module prio_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic         gnt_vld,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic           vld_q, vld_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [N-1:0]   onehot_q, onehot_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic           rr_q, rr_d;
  logic [W-1:0]   win;

  // Descending search from start, wrapping below 0 back to N-1; first set bit wins.
  function automatic logic [W-1:0] pick(input logic [N-1:0] r, input logic [W-1:0] start);
    logic [W-1:0] w;
    logic [W-1:0] pos;
    logic         found;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = W'((int'(start) + N - k) % N);
      if (!found && r[pos]) begin
        w     = pos;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign win = pick(req, mode ? ptr_q : W'(N - 1));

  always_comb begin
    state_d  = state_q;
    vld_d    = vld_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    rr_d     = rr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d       = GRANT;
          vld_d         = 1'b1;
          idx_d         = win;
          onehot_d      = '0;
          onehot_d[win] = 1'b1;
          rr_d          = mode;
        end
      end
      GRANT: begin
        if (ack) begin
          state_d  = IDLE;
          vld_d    = 1'b0;
          idx_d    = '0;
          onehot_d = '0;
          // Pointer moves only if this grant was won under round-robin.
          if (rr_q) ptr_d = (idx_q == '0) ? W'(N - 1) : idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      vld_q    <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= W'(N - 1);
      rr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
      rr_q     <= rr_d;
    end
  end

  assign gnt_vld    = vld_q;
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// tb/tb_prio_arbiter.sv - directed self-checking bench for prio_arbiter (N=8 and N=5)
module tb_prio_arbiter;

  logic       clk;
  logic       rst_b;
  logic [7:0] req;
  logic       mode;
  logic       ack;
  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;

  logic [4:0] req5;
  logic       mode5;
  logic       ack5;
  logic       gnt_vld5;
  logic [2:0] gnt_idx5;
  logic [4:0] gnt_onehot5;

  int checks = 0;
  int errors = 0;

  prio_arbiter #(.N(8)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .mode(mode), .ack(ack),
    .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot)
  );

  prio_arbiter #(.N(5)) dut5 (
    .clk(clk), .rst_b(rst_b), .req(req5), .mode(mode5), .ack(ack5),
    .gnt_vld(gnt_vld5), .gnt_idx(gnt_idx5), .gnt_onehot(gnt_onehot5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; req = '0; mode = 1'b0; ack = 1'b0;
    req5 = '0; mode5 = 1'b0; ack5 = 1'b0;
    step(); step();
    rst_b = 1'b1;
    req = 8'b0010_0000;
    step();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 3'd5) begin
      errors++; $display("FAIL reset_pre_grant got vld=%0d idx=%0d exp vld=1 idx=5", gnt_vld, gnt_idx);
    end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if (gnt_vld !== 1'b0 || gnt_onehot !== 8'h00 || gnt_idx !== 3'd0) begin
      errors++; $display("FAIL reset_async got vld=%0d idx=%0d oh=%h exp 0 0 00", gnt_vld, gnt_idx, gnt_onehot);
    end
    req = '0;
    step();
    rst_b = 1'b1;
    step(); step();
    checks++;
    if (gnt_vld !== 1'b0 || gnt_onehot !== 8'h00 || gnt_idx !== 3'd0) begin
      errors++; $display("FAIL reset_idle got vld=%0d idx=%0d oh=%h exp 0 0 00", gnt_vld, gnt_idx, gnt_onehot);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0;
    req  = 8'b0010_1100;
    step();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 3'd5 || gnt_onehot !== 8'b0010_0000) begin
      errors++; $display("FAIL fixed_grant got vld=%0d idx=%0d oh=%b exp 1 5 00100000", gnt_vld, gnt_idx, gnt_onehot);
    end
    req = 8'b1000_0000;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (gnt_vld !== 1'b1 || gnt_idx !== 3'd5) begin
        errors++; $display("FAIL fixed_hold%0d got vld=%0d idx=%0d exp 1 5", i, gnt_vld, gnt_idx);
      end
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if (gnt_vld !== 1'b0 || gnt_onehot !== 8'h00) begin
      errors++; $display("FAIL fixed_ack got vld=%0d oh=%h exp 0 00", gnt_vld, gnt_onehot);
    end
    step();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 3'd7 || gnt_onehot !== 8'b1000_0000) begin
      errors++; $display("FAIL fixed_regrant got vld=%0d idx=%0d oh=%b exp 1 7 10000000", gnt_vld, gnt_idx, gnt_onehot);
    end
    ack = 1'b1; req = '0;
    step();
    ack = 1'b0;
  endtask

  task automatic test_rr_fair();
    logic [2:0] exp_seq [9];
    exp_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    mode = 1'b1;
    req  = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (gnt_vld !== 1'b1 || gnt_idx !== exp_seq[i]) begin
        errors++; $display("FAIL rr_fair%0d got vld=%0d idx=%0d exp 1 %0d", i, gnt_vld, gnt_idx, exp_seq[i]);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++;
      if (gnt_vld !== 1'b0) begin
        errors++; $display("FAIL rr_fair_gap%0d got vld=%0d exp 0", i, gnt_vld);
      end
    end
    req = '0;
  endtask

  task automatic test_rr_wrap();
    logic [2:0] exp_seq [3];
    exp_seq = '{3'd1, 3'd0, 3'd1};
    mode = 1'b1;
    req  = 8'b0000_0001;
    step();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 3'd0) begin
      errors++; $display("FAIL rr_wrap_pre got vld=%0d idx=%0d exp 1 0", gnt_vld, gnt_idx);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    req = 8'b0000_0011;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (gnt_vld !== 1'b1 || gnt_idx !== exp_seq[i]) begin
        errors++; $display("FAIL rr_wrap%0d got vld=%0d idx=%0d exp 1 %0d", i, gnt_vld, gnt_idx, exp_seq[i]);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
    end
    req = '0;
  endtask

  task automatic test_lock();
    mode = 1'b0;
    req  = 8'b0000_0100;
    step();
    checks++;
    if (gnt_vld !== 1'b1 || gnt_idx !== 3'd2 || gnt_onehot !== 8'b0000_0100) begin
      errors++; $display("FAIL lock_grant got vld=%0d idx=%0d oh=%b exp 1 2 00000100", gnt_vld, gnt_idx, gnt_onehot);
    end
    req = '0;
    for (int i = 0; i < 3; i++) begin
      mode = ~mode;
      step();
      checks++;
      if (gnt_vld !== 1'b1 || gnt_idx !== 3'd2) begin
        errors++; $display("FAIL lock_hold%0d got vld=%0d idx=%0d exp 1 2", i, gnt_vld, gnt_idx);
      end
    end
    mode = 1'b0;
    ack  = 1'b1;
    step();
    checks++;
    if (gnt_vld !== 1'b0) begin
      errors++; $display("FAIL lock_release got vld=%0d exp 0", gnt_vld);
    end
    step(); step();
    ack = 1'b0;
    checks++;
    if (gnt_vld !== 1'b0 || gnt_idx !== 3'd0 || gnt_onehot !== 8'h00) begin
      errors++; $display("FAIL idle_ack got vld=%0d idx=%0d oh=%h exp 0 0 00", gnt_vld, gnt_idx, gnt_onehot);
    end
  endtask

  task automatic test_n5();
    logic [2:0] exp_seq [4];
    logic [4:0] exp_oh [4];
    exp_seq = '{3'd4, 3'd0, 3'd4, 3'd0};
    exp_oh  = '{5'b10000, 5'b00001, 5'b10000, 5'b00001};
    mode5 = 1'b1;
    req5  = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (gnt_vld5 !== 1'b1 || gnt_idx5 !== exp_seq[i] || gnt_onehot5 !== exp_oh[i]) begin
        errors++; $display("FAIL n5_grant%0d got vld=%0d idx=%0d oh=%b exp 1 %0d %b", i, gnt_vld5, gnt_idx5, gnt_onehot5, exp_seq[i], exp_oh[i]);
      end
      checks++;
      if (gnt_idx5 > 3'd4) begin
        errors++; $display("FAIL n5_range%0d got idx=%0d exp <=4", i, gnt_idx5);
      end
      ack5 = 1'b1;
      step();
      ack5 = 1'b0;
    end
    req5 = '0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_fair();
    test_rr_wrap();
    test_lock();
    test_n5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
